// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer and its surroundings (microcode ROM, datapath, condition logic).
// No valid/ready: the ROM answers combinationally in the same cycle; hold is the only flow control.
interface micro_sequencer_if #(
  parameter int ADDR_W      = 4,
  parameter int CTRL_W      = 22,
  parameter int COND_W      = 4,
  parameter int DISP_W      = 2,
  parameter int STACK_DEPTH = 4
);
  localparam int SEL_W = $clog2(COND_W);
  localparam int UI_W  = 3 + 1 + SEL_W + ADDR_W + CTRL_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  logic              hold;
  logic [COND_W-1:0] cond_in;
  logic [DISP_W-1:0] disp_in;
  logic [UI_W-1:0]   uinstr;
  logic [ADDR_W-1:0] upc_addr;
  logic [CTRL_W-1:0] ctrl_out;
  logic              halted;
  logic              stack_err;
  logic [SP_W-1:0]   sp_dbg;

  modport master (
    input  hold, cond_in, disp_in, uinstr,
    output upc_addr, ctrl_out, halted, stack_err, sp_dbg
  );

  modport slave (
    output hold, cond_in, disp_in, uinstr,
    input  upc_addr, ctrl_out, halted, stack_err, sp_dbg
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the micro-PC, decodes the ROM word into a control bus and
// a next-address op (increment/jump/branch/wait/dispatch/call/return/halt) with a return stack.
module micro_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int CTRL_W      = 22,
  parameter int COND_W      = 4,
  parameter int DISP_W      = 2,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input logic              clk,
  input logic              rst_n,
  micro_sequencer_if.master bus
);
  localparam int SEL_W = $clog2(COND_W);
  localparam int UI_W  = 3 + 1 + SEL_W + ADDR_W + CTRL_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SUM_W = (ADDR_W > DISP_W) ? ADDR_W : DISP_W;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_BR   = 3'd2,
    OP_WAIT = 3'd3,
    OP_DISP = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push_en;

  op_e               op;
  logic              pol;
  logic [SEL_W-1:0]  csel;
  logic [ADDR_W-1:0] target;
  logic              cond;
  logic [ADDR_W-1:0] inc;
  logic [SUM_W-1:0]  disp_sum;
  logic [SP_W-1:0]   sp_m1;
  logic              advance;

  assign op       = op_e'(bus.uinstr[UI_W-1 -: 3]);
  assign pol      = bus.uinstr[UI_W-4];
  assign csel     = bus.uinstr[CTRL_W+ADDR_W +: SEL_W];
  assign target   = bus.uinstr[CTRL_W +: ADDR_W];
  assign cond     = bus.cond_in[csel] ^ pol;
  assign inc      = upc_q + ADDR_W'(1);
  assign disp_sum = SUM_W'(target) + SUM_W'(bus.disp_in);
  assign sp_m1    = sp_q - SP_W'(1);
  assign advance  = !bus.hold && !halted_q;

  always_comb begin
    upc_d    = upc_q;
    sp_d     = sp_q;
    halted_d = halted_q;
    err_d    = err_q;
    push_en  = 1'b0;
    if (advance) begin
      case (op)
        OP_NEXT: upc_d = inc;
        OP_JMP:  upc_d = target;
        OP_BR:   upc_d = cond ? target : inc;
        OP_WAIT: upc_d = cond ? inc : upc_q;
        OP_DISP: upc_d = disp_sum[ADDR_W-1:0];
        OP_CALL: begin
          // A full stack still takes the jump; only the return address is lost.
          upc_d = target;
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            upc_d = ADDR_W'(RESET_ADDR);
            err_d = 1'b1;
          end else begin
            upc_d = stack_q[sp_m1[IDX_W-1:0]];
            sp_d  = sp_m1;
          end
        end
        OP_HALT: halted_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q    <= ADDR_W'(RESET_ADDR);
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      upc_q    <= upc_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Stack entries above sp are don't-care, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q[IDX_W-1:0]] <= inc;
    end
  end

  assign bus.upc_addr  = upc_q;
  assign bus.ctrl_out  = rst_n ? bus.uinstr[CTRL_W-1:0] : '0;
  assign bus.halted    = halted_q;
  assign bus.stack_err = err_q;
  assign bus.sp_dbg    = sp_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: ROM array owned by the bench, a queue-based reference model,
// directed microprograms with literal expectations, then a randomized program/input run.
module tb_micro_sequencer;
  logic clk;
  logic rst_n;

  micro_sequencer_if #(.ADDR_W(4), .CTRL_W(22), .COND_W(4), .DISP_W(2), .STACK_DEPTH(4)) bus ();

  micro_sequencer #(
    .ADDR_W(4), .CTRL_W(22), .COND_W(4), .DISP_W(2), .STACK_DEPTH(4), .RESET_ADDR(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rom [16];
  assign bus.uinstr = rom[bus.upc_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  int passed;
  int total;

  // reference model
  int   m_upc;
  int   stk[$];
  bit   m_halted;
  bit   m_err;

  function automatic logic [31:0] mk(int op, int pol, int csel, int tgt, logic [21:0] ctrl);
    return {3'(op), 1'(pol), 2'(csel), 4'(tgt), ctrl};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_upc    = 0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    stk.delete();
  endtask

  task automatic model_step();
    logic [31:0] w;
    int op, pol, csel, tgt, inc, c;
    if (bus.hold || m_halted) return;
    w    = rom[m_upc];
    op   = int'(w[31:29]);
    pol  = int'(w[28]);
    csel = int'(w[27:26]);
    tgt  = int'(w[25:22]);
    inc  = (m_upc + 1) % 16;
    c    = int'(bus.cond_in[csel]) ^ pol;
    case (op)
      0: m_upc = inc;
      1: m_upc = tgt;
      2: m_upc = c ? tgt : inc;
      3: m_upc = c ? inc : m_upc;
      4: m_upc = (tgt + int'(bus.disp_in)) % 16;
      5: begin
        if (stk.size() == 4) m_err = 1'b1;
        else stk.push_back(inc);
        m_upc = tgt;
      end
      6: begin
        if (stk.size() == 0) begin
          m_upc = 0;
          m_err = 1'b1;
        end else begin
          m_upc = stk.pop_back();
        end
      end
      default: m_halted = 1'b1;
    endcase
  endtask

  task automatic compare();
    logic [31:0] w;
    w = rom[m_upc];
    check("upc_addr", 32'(bus.upc_addr), 32'(m_upc));
    check("ctrl_out", 32'(bus.ctrl_out), 32'(w[21:0]));
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("stack_err", 32'(bus.stack_err), 32'(m_err));
    check("sp", 32'(bus.sp_dbg), 32'(stk.size()));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_upc", 32'(bus.upc_addr), 32'd0);
    check("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_err", 32'(bus.stack_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_next();
    for (int i = 0; i < 16; i++) rom[i] = mk(0, 0, 0, 0, 22'($urandom));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:29] == 3'd7 && $urandom_range(0, 3) != 0) w[31:29] = 3'd0;
    return w;
  endfunction

  initial begin
    passed       = 0;
    total        = 0;
    rst_n        = 1'b0;
    bus.hold     = 1'b0;
    bus.cond_in  = '0;
    bus.disp_in  = '0;
    fill_next();
    model_reset();
    @(negedge clk);

    // reset mid-program at upc 7
    apply_reset();
    ticks(7);
    check("run_to_7", 32'(bus.upc_addr), 32'd7);
    apply_reset();

    // BR taken / not taken
    fill_next();
    rom[2] = mk(2, 0, 1, 9, 22'h2aaaa);
    bus.cond_in = 4'b0010;
    apply_reset();
    ticks(3);
    check("br_taken", 32'(bus.upc_addr), 32'd9);
    bus.cond_in = 4'b0000;
    apply_reset();
    ticks(3);
    check("br_not_taken", 32'(bus.upc_addr), 32'd3);

    // WAIT spins until cond_in[0]
    rom[5] = mk(3, 0, 0, 0, 22'h15555);
    apply_reset();
    ticks(8);
    check("wait_spin", 32'(bus.upc_addr), 32'd5);
    bus.cond_in = 4'b0001;
    tick();
    check("wait_release", 32'(bus.upc_addr), 32'd6);

    // dispatch, including wrap
    rom[0] = mk(4, 0, 0, 8, 22'h00123);
    bus.disp_in = 2'b11;
    apply_reset();
    tick();
    check("disp_8_3", 32'(bus.upc_addr), 32'd11);
    rom[0] = mk(4, 0, 0, 14, 22'h00456);
    apply_reset();
    tick();
    check("disp_wrap", 32'(bus.upc_addr), 32'd1);

    // single call / return
    fill_next();
    rom[4]  = mk(5, 0, 0, 10, 22'h3ffff);
    rom[10] = mk(6, 0, 0, 0, 22'h0f0f0);
    apply_reset();
    ticks(5);
    check("call_target", 32'(bus.upc_addr), 32'd10);
    check("call_sp", 32'(bus.sp_dbg), 32'd1);
    tick();
    check("ret_addr", 32'(bus.upc_addr), 32'd5);

    // four nested calls, fifth overflows, LIFO unwind, then halt
    fill_next();
    rom[0]  = mk(5, 0, 0, 2, 22'h1);
    rom[2]  = mk(5, 0, 0, 4, 22'h2);
    rom[4]  = mk(5, 0, 0, 6, 22'h3);
    rom[6]  = mk(5, 0, 0, 8, 22'h4);
    rom[8]  = mk(5, 0, 0, 10, 22'h5);
    rom[10] = mk(6, 0, 0, 0, 22'h6);
    rom[7]  = mk(6, 0, 0, 0, 22'h7);
    rom[5]  = mk(6, 0, 0, 0, 22'h8);
    rom[3]  = mk(6, 0, 0, 0, 22'h9);
    rom[1]  = mk(7, 0, 0, 0, 22'ha);
    apply_reset();
    ticks(5);
    check("ovf_jump", 32'(bus.upc_addr), 32'd10);
    check("ovf_err", 32'(bus.stack_err), 32'd1);
    check("ovf_sp", 32'(bus.sp_dbg), 32'd4);
    tick(); check("unwind_1", 32'(bus.upc_addr), 32'd7);
    tick(); check("unwind_2", 32'(bus.upc_addr), 32'd5);
    tick(); check("unwind_3", 32'(bus.upc_addr), 32'd3);
    tick(); check("unwind_4", 32'(bus.upc_addr), 32'd1);
    tick(); check("halt_after_unwind", 32'(bus.halted), 32'd1);

    // underflow
    fill_next();
    rom[3] = mk(6, 0, 0, 0, 22'h11111);
    apply_reset();
    ticks(4);
    check("udf_upc", 32'(bus.upc_addr), 32'd0);
    check("udf_err", 32'(bus.stack_err), 32'd1);

    // halt at 12, frozen for 10 clocks, cleared by reset
    fill_next();
    rom[12] = mk(7, 0, 0, 3, 22'h22222);
    apply_reset();
    ticks(13);
    check("halt_set", 32'(bus.halted), 32'd1);
    ticks(10);
    check("halt_frozen", 32'(bus.upc_addr), 32'd12);
    apply_reset();

    // hold during CALL (reset asserted while hold is high), then release
    fill_next();
    rom[0] = mk(5, 0, 0, 10, 22'h33333);
    bus.hold = 1'b1;
    apply_reset();
    ticks(3);
    check("hold_upc", 32'(bus.upc_addr), 32'd0);
    check("hold_sp", 32'(bus.sp_dbg), 32'd0);
    bus.hold = 1'b0;
    tick();
    check("hold_release", 32'(bus.upc_addr), 32'd10);

    // wrap from 15 to 0
    fill_next();
    apply_reset();
    ticks(15);
    check("at_15", 32'(bus.upc_addr), 32'd15);
    tick();
    check("wrap_0", 32'(bus.upc_addr), 32'd0);

    // randomized programs and inputs
    for (int i = 0; i < 16; i++) rom[i] = rand_word();
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.hold    = ($urandom_range(0, 7) == 0);
      bus.cond_in = 4'($urandom);
      bus.disp_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) rom[$urandom_range(0, 15)] = rand_word();
      if ($urandom_range(0, 40) == 0) apply_reset();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
